// File: rtl/spi_port_master.sv
// SPI master for the board window: register strobes in, one whole word shifted
// out/in autonomously with run-time mode, divider, bit order and chip selects.
module spi_port_master #(
  parameter int CS_COUNT  = 4,
  parameter int XFER_BITS = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                cpu_clk_i,
  input  logic                reset_i,
  input  logic [1:0]          reg_sel_i,
  input  logic                reg_wr_i,
  input  logic                reg_rd_i,
  input  logic [15:0]         wdata_i,
  output logic [15:0]         rdata_o,
  output logic                ack_o,
  output logic                busy_o,
  output logic                irq_o,
  output logic [CS_COUNT-1:0] spi_cs_o,
  output logic                spi_sck_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i
);

  localparam int EW = $clog2(2 * XFER_BITS + 1);

  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_CTRL = 2'd1;
  localparam logic [1:0] SEL_DIV  = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]          edge_q, edge_d;
  logic [XFER_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [XFER_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [XFER_BITS-1:0]   rx_q, rx_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic [CS_COUNT-1:0]    cs_mask_q, cs_mask_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   lsb_q, lsb_d;
  logic                   irq_en_q, irq_en_d;
  logic                   auto_cs_q, auto_cs_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   ack_q, ack_d;
  logic [15:0]            rdata_q, rdata_d;

  logic                   busy;
  logic                   wr_data;
  logic                   lead_edge;
  logic                   last_edge;
  logic [15:0]            rd_word;
  logic                   unused_wdata;

  // The bit that leaves the shift register next, given the bit order.
  function automatic logic out_bit(input logic [XFER_BITS-1:0] v, input logic lsb);
    return lsb ? v[0] : v[XFER_BITS-1];
  endfunction

  // Advance the shift register by one bit towards the output end.
  function automatic logic [XFER_BITS-1:0] advance(input logic [XFER_BITS-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign busy      = (state_q != IDLE);
  assign wr_data   = reg_wr_i && (reg_sel_i == SEL_DATA);
  // The edge about to happen is odd (leading) when the count so far is even.
  assign lead_edge = ~edge_q[0];
  assign last_edge = (edge_q == EW'(2 * XFER_BITS - 1));

  // Upper write-data bits beyond the widest field are intentionally ignored.
  assign unused_wdata = ^wdata_i;

  // Next-state, register-file and shifting logic.
  always_comb begin
    // NOTE: every _d gets its current value first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_d      = rx_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_mask_d = cs_mask_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    irq_en_d  = irq_en_q;
    auto_cs_d = auto_cs_q;
    div_d     = div_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    ack_d     = reg_wr_i | reg_rd_i;
    rd_word   = '0;

    // Configuration only changes between transfers.
    if (reg_wr_i && !busy) begin
      if (reg_sel_i == SEL_CTRL) begin
        cs_mask_d = wdata_i[CS_COUNT-1:0];
        cpol_d    = wdata_i[8];
        cpha_d    = wdata_i[9];
        lsb_d     = wdata_i[10];
        irq_en_d  = wdata_i[11];
        auto_cs_d = wdata_i[12];
      end else if (reg_sel_i == SEL_DIV) begin
        div_d = wdata_i[DIV_WIDTH-1:0];
      end
    end

    unique case (reg_sel_i)
      SEL_DATA: rd_word[XFER_BITS-1:0] = rx_q;
      SEL_CTRL: begin
        rd_word[CS_COUNT-1:0] = cs_mask_q;
        rd_word[8]            = cpol_q;
        rd_word[9]            = cpha_q;
        rd_word[10]           = lsb_q;
        rd_word[11]           = irq_en_q;
        rd_word[12]           = auto_cs_q;
      end
      SEL_DIV:  rd_word[DIV_WIDTH-1:0] = div_q;
      default:  rd_word[2:0] = {overrun_q, done_q, busy};
    endcase
    rdata_d = reg_rd_i ? rd_word : '0;

    // Read-to-clear first so that a same-cycle set takes priority below.
    if (reg_rd_i && reg_sel_i == SEL_DATA) done_d = 1'b0;
    if (reg_rd_i && reg_sel_i == 2'd3)     overrun_d = 1'b0;
    if (wr_data && busy)                   overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (wr_data) begin
          state_d = SHIFT;
          cnt_d   = '0;
          edge_d  = '0;
          sck_d   = cpol_q;
          rx_sr_d = '0;
          if (cpha_q) begin
            tx_sr_d = wdata_i[XFER_BITS-1:0];
          end else begin
            // First bit is on the wire from the load cycle onward.
            mosi_d  = out_bit(wdata_i[XFER_BITS-1:0], lsb_q);
            tx_sr_d = advance(wdata_i[XFER_BITS-1:0], lsb_q);
          end
        end
      end
      SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d  = '0;
          edge_d = edge_q + 1'b1;
          sck_d  = ~sck_q;
          if (lead_edge != cpha_q) begin
            rx_sr_d = lsb_q ? {spi_miso_i, rx_sr_q[XFER_BITS-1:1]}
                            : {rx_sr_q[XFER_BITS-2:0], spi_miso_i};
          end else if (cpha_q || !last_edge) begin
            // With CPHA=0 the final trailing edge has no further bit to drive.
            mosi_d  = out_bit(tx_sr_q, lsb_q);
            tx_sr_d = advance(tx_sr_q, lsb_q);
          end
          if (last_edge) state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        rx_d    = rx_sr_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge cpu_clk_i) begin
    // NOTE: reset is sampled on the clock edge here; there is no async path.
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_q      <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_mask_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      auto_cs_q <= 1'b0;
      div_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_q      <= rx_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_mask_q <= cs_mask_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      irq_en_q  <= irq_en_d;
      auto_cs_q <= auto_cs_d;
      div_q     <= div_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign ack_o      = ack_q;
  assign busy_o     = busy;
  assign irq_o      = done_q & irq_en_q;
  assign spi_sck_o  = (state_q == SHIFT) ? sck_q : cpol_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_o   = (auto_cs_q && !busy) ? '1 : ~cs_mask_q;

endmodule

// File: tb/tb_spi_port_master.sv
// Randomised bench for spi_port_master: an edge-counting SPI slave model
// captures MOSI and serves MISO, and transfer timing is derived from the
// divider and word length.
module tb_spi_port_master;

  localparam int CS_COUNT  = 4;
  localparam int XFER_BITS = 8;
  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_CTRL = 2'd1;
  localparam logic [1:0] R_DIV  = 2'd2;
  localparam logic [1:0] R_STAT = 2'd3;

  localparam int M_PLAIN   = 0;
  localparam int M_OVERRUN = 1;
  localparam int M_FINRD   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          reg_sel = '0;
  logic                reg_wr = 1'b0;
  logic                reg_rd = 1'b0;
  logic [15:0]         wdata = '0;
  logic [15:0]         rdata;
  logic                ack, busy, irq;
  logic [CS_COUNT-1:0] spi_cs;
  logic                sck, mosi;
  logic                miso = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the programmed configuration.
  logic [CS_COUNT-1:0] cfg_mask;
  logic                cfg_cpol, cfg_cpha, cfg_lsb, cfg_irq, cfg_auto;
  int                  cfg_div;

  spi_port_master #(
    .CS_COUNT (CS_COUNT),
    .XFER_BITS(XFER_BITS),
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .cpu_clk_i (clk),
    .reset_i   (rst),
    .reg_sel_i (reg_sel),
    .reg_wr_i  (reg_wr),
    .reg_rd_i  (reg_rd),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .ack_o     (ack),
    .busy_o    (busy),
    .irq_o     (irq),
    .spi_cs_o  (spi_cs),
    .spi_sck_o (sck),
    .spi_mosi_o(mosi),
    .spi_miso_i(miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int phys(input int j, input logic lsb);
    return lsb ? j : (XFER_BITS - 1 - j);
  endfunction

  function automatic logic [15:0] ctrl_word(input logic [CS_COUNT-1:0] m, input logic cpol,
                                            input logic cpha, input logic lsb,
                                            input logic ien, input logic acs);
    logic [15:0] w;
    w = '0;
    w[CS_COUNT-1:0] = m;
    w[8]  = cpol;
    w[9]  = cpha;
    w[10] = lsb;
    w[11] = ien;
    w[12] = acs;
    return w;
  endfunction

  function automatic logic [CS_COUNT-1:0] cs_idle_exp();
    return cfg_auto ? '1 : ~cfg_mask;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic reg_write(input logic [1:0] sel, input logic [15:0] d);
    reg_sel = sel;
    wdata   = d;
    reg_wr  = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    check("ack_wr", ack, 1);
    @(negedge clk);
    check("ack_wr_low", ack, 0);
  endtask

  task automatic reg_read(input logic [1:0] sel, output logic [15:0] d, output logic irq_s);
    reg_sel = sel;
    reg_rd  = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0;
    check("ack_rd", ack, 1);
    d     = rdata;
    irq_s = irq;
    @(negedge clk);
    check("ack_rd_low", ack, 0);
  endtask

  task automatic configure(input logic [CS_COUNT-1:0] m, input logic cpol, input logic cpha,
                           input logic lsb, input logic ien, input logic acs, input int div);
    reg_write(R_CTRL, ctrl_word(m, cpol, cpha, lsb, ien, acs));
    reg_write(R_DIV, 16'(div));
    cfg_mask = m;  cfg_cpol = cpol; cfg_cpha = cpha;
    cfg_lsb  = lsb; cfg_irq = ien;  cfg_auto = acs;
    cfg_div  = div;
  endtask

  // One transfer with a protocol-level slave. Returns the word the slave saw
  // on MOSI. rst_edge>0 asserts RESET once that many SCK edges were seen.
  task automatic do_xfer(input logic [15:0] tx, input logic [15:0] sw, input bit loopback,
                         input int mode, input int rst_edge, output logic [15:0] cap);
    int          exp_len, busy_cnt, edges, rises, gap, gap_bad, cs_bad, guard, j, nb;
    logic        prev, lead;
    logic [15:0] d;
    exp_len = 2 * XFER_BITS * (cfg_div + 1) + 1;
    cap = '0;
    busy_cnt = 0; edges = 0; rises = 0; gap = 0; gap_bad = 0; cs_bad = 0; guard = 0;
    prev = cfg_cpol;
    check("cs_before", spi_cs, cs_idle_exp());
    if (!cfg_cpha && !loopback) miso = sw[phys(0, cfg_lsb)];
    reg_sel = R_DATA;
    wdata   = tx;
    reg_wr  = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    check("ack_data_wr", ack, 1);
    while (busy && guard < 5000) begin
      busy_cnt++;
      guard++;
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      if (loopback) miso = mosi;
      gap++;
      if (sck != prev) begin
        edges++;
        if (sck) rises++;
        if (edges > 1 && gap != cfg_div + 1) gap_bad++;
        gap  = 0;
        prev = sck;
        lead = (edges % 2) == 1;
        if (lead != cfg_cpha) begin
          j = (edges - 1) / 2;
          cap[phys(j, cfg_lsb)] = mosi;
        end else if (!loopback) begin
          nb = cfg_cpha ? (edges - 1) / 2 : edges / 2;
          if (nb < XFER_BITS) miso = sw[phys(nb, cfg_lsb)];
        end
        if (rst_edge != 0 && edges == rst_edge) begin
          rst = 1'b1;
          return;
        end
      end
      if (spi_cs != ~cfg_mask) cs_bad++;
      if (mode == M_OVERRUN) begin
        case (busy_cnt)
          2:  begin reg_sel = R_DATA; wdata = ~tx; reg_wr = 1'b1; end
          3:  check("ovr_ack_wr", ack, 1);
          4:  begin check("ovr_ack_low", ack, 0); reg_sel = R_STAT; reg_rd = 1'b1; end
          5:  begin check("ovr_ack_rd1", ack, 1); check("ovr_status1", rdata, 16'h0005); end
          6:  begin reg_sel = R_STAT; reg_rd = 1'b1; end
          7:  begin check("ovr_ack_rd2", ack, 1); check("ovr_status2", rdata, 16'h0001); end
          8:  begin reg_sel = R_CTRL; wdata = 16'h0000; reg_wr = 1'b1; end
          9:  check("busy_ctrl_ack", ack, 1);
          10: begin reg_sel = R_DIV; wdata = 16'h0000; reg_wr = 1'b1; end
          11: check("busy_div_ack", ack, 1);
          default: ;
        endcase
      end
      if (mode == M_FINRD && busy_cnt == exp_len) begin
        check("irq_before_done", irq, 0);
        reg_sel = R_DATA;
        reg_rd  = 1'b1;
      end
      @(negedge clk);
    end
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    check("busy_timeout", guard < 5000, 1);
    check("busy_len", busy_cnt, exp_len);
    check("sck_edges", edges, 2 * XFER_BITS);
    check("sck_rises", rises, XFER_BITS);
    check("sck_half_period", gap_bad, 0);
    check("cs_during", cs_bad, 0);
    check("sck_idle", sck, cfg_cpol);
    check("cs_after", spi_cs, cs_idle_exp());
    check("irq_at_done", irq, cfg_irq);
    if (mode == M_FINRD) check("ack_fin_rd", ack, 1);
    d = '0;
  endtask

  logic [15:0] cap, d, tx, sw;
  logic        irq_s;

  initial begin
    cfg_mask = '0; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_irq = 0; cfg_auto = 0; cfg_div = 0;
    repeat (3) @(negedge clk);
    check("rst_cs", spi_cs, {CS_COUNT{1'b1}});
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, DIV=0, AUTO_CS, MISO looped back to MOSI.
    configure(4'h1, 0, 0, 0, 0, 1, 0);
    reg_read(R_CTRL, d, irq_s);
    check("ctrl_readback", d, 16'h1001);
    check("cs_auto_idle", spi_cs, 4'hF);
    do_xfer(16'h00A5, 16'h0000, 1, M_PLAIN, 0, cap);
    check("m0_mosi_word", cap, 16'h00A5);
    reg_read(R_STAT, d, irq_s);
    check("m0_status_done", d, 16'h0002);
    reg_read(R_DATA, d, irq_s);
    check("m0_rx", d, 16'h00A5);
    reg_read(R_STAT, d, irq_s);
    check("m0_done_cleared", d, 16'h0000);

    // Mode 3, LSB first, DIV=3.
    configure(4'h2, 1, 1, 1, 0, 0, 3);
    reg_read(R_DIV, d, irq_s);
    check("div_readback", d, 16'h0003);
    check("m3_sck_idle", sck, 1);
    do_xfer(16'h003C, 16'h0081, 0, M_PLAIN, 0, cap);
    check("m3_mosi_seq", cap, 16'h003C);
    reg_read(R_DATA, d, irq_s);
    check("m3_rx", d, 16'h0081);

    // DATA/CONTROL/DIVIDER writes while busy.
    configure(4'h4, 0, 0, 0, 0, 0, 2);
    do_xfer(16'h005A, 16'h00C3, 0, M_OVERRUN, 0, cap);
    check("ovr_tx_unchanged", cap, 16'h005A);
    reg_read(R_DATA, d, irq_s);
    check("ovr_rx", d, 16'h00C3);
    reg_read(R_CTRL, d, irq_s);
    check("ovr_ctrl_kept", d, 16'h0004);
    reg_read(R_STAT, d, irq_s);
    check("ovr_status_end", d, 16'h0000);

    // IRQ, and a DATA read landing in the FINISH cycle.
    configure(4'h8, 0, 1, 0, 1, 1, 1);
    do_xfer(16'h0096, 16'h0017, 0, M_FINRD, 0, cap);
    check("irq_mosi", cap, 16'h0096);
    reg_read(R_STAT, d, irq_s);
    check("irq_done_kept", d, 16'h0002);
    check("irq_high", irq_s, 1);
    reg_read(R_DATA, d, irq_s);
    check("irq_rx", d, 16'h0017);
    check("irq_falls", irq_s, 0);

    // Back-to-back transfers: next DATA write in the first idle cycle.
    configure(4'h3, 1, 0, 1, 0, 0, 0);
    do_xfer(16'h00E1, 16'h0033, 0, M_PLAIN, 0, cap);
    check("b2b_mosi1", cap, 16'h00E1);
    do_xfer(16'h001E, 16'h00CC, 0, M_PLAIN, 0, cap);
    check("b2b_mosi2", cap, 16'h001E);
    reg_read(R_DATA, d, irq_s);
    check("b2b_rx2", d, 16'h00CC);

    // Randomised configurations and data.
    for (int t = 0; t < 12; t++) begin
      configure(CS_COUNT'($urandom_range(1, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      tx = 16'($urandom_range(0, 255));
      sw = 16'($urandom_range(0, 255));
      do_xfer(tx, sw, 0, M_PLAIN, 0, cap);
      check("rand_mosi", cap, tx);
      reg_read(R_DATA, d, irq_s);
      check("rand_rx", d, sw);
      check("rand_irq_clr", irq_s, 0);
      reg_read(R_STAT, d, irq_s);
      check("rand_status", d, 16'h0000);
    end

    // RESET at SCK edge 5 of a transfer.
    configure(4'h5, 1, 0, 0, 1, 0, 1);
    do_xfer(16'h00FF, 16'h00AA, 0, M_PLAIN, 5, cap);
    @(negedge clk);
    check("mid_rst_cs", spi_cs, {CS_COUNT{1'b1}});
    check("mid_rst_sck", sck, 0);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_ack", ack, 0);
    rst = 1'b0;
    @(negedge clk);
    reg_read(R_CTRL, d, irq_s);
    check("mid_rst_ctrl", d, 16'h0000);
    reg_read(R_STAT, d, irq_s);
    check("mid_rst_status", d, 16'h0000);
    reg_read(R_DIV, d, irq_s);
    check("mid_rst_div", d, 16'h0000);
    reg_read(R_DATA, d, irq_s);
    check("mid_rst_rx", d, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_port_master.md
# spi_port_master

Hardware SPI master for the accelerator's autoconfigured SPI board window, superseding the bit-banged CS/MOSI/SCK latch. The bus decoder hands it single-cycle register strobes in the CPU_CLK domain. It then shifts a whole word autonomously, with run-time clock mode, divider, bit order and chip-select selection. It is parametrised in chip-select count, transfer width and divider width, and adds status, overrun detection and an interrupt.

## Interface
- CS_COUNT, 4: number of active-low chip selects (1..8).
- XFER_BITS, 8: bits per transfer (2..16).
- DIV_WIDTH, 8: width of the SCK divider register (1..12).

- CPU_CLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REG_SEL  in  2  register select: 0 DATA, 1 CONTROL, 2 DIVIDER, 3 STATUS.
- REG_WR  in  1  one-cycle write strobe.
- REG_RD  in  1  one-cycle read strobe (never simultaneous with REG_WR).
- WDATA  in  16  write data.
- RDATA  out  16  read data, registered; valid while ACK is high.
- ACK  out  1  one-cycle pulse, the cycle after any REG_WR/REG_RD; used by the decoder for DTACK.
- BUSY  out  1  transfer in progress.
- IRQ  out  1  DONE & IRQ_EN, level.
- SPI_CS  out  CS_COUNT  active-low chip selects.
- SPI_SCK  out  1  serial clock.
- SPI_MOSI  out  1  serial data out.
- SPI_MISO  in  1  serial data in; externally synchronised.

## Operation
- CONTROL holds CS_MASK[CS_COUNT-1:0] at bits [7:0] (1 = select), CPOL at bit 8, CPHA at bit 9, LSB_FIRST at bit 10, IRQ_EN at bit 11 and AUTO_CS at bit 12. Unused bits read 0.
- DIVIDER: SCK half-period = DIV+1 clocks.
- STATUS read: bit0 BUSY, bit1 DONE, bit2 OVERRUN.
- STATUS read clears OVERRUN after the value is captured.
- DATA read returns the RX word, zero-extended, and clears DONE.
- States: IDLE, SHIFT, FINISH.
- IDLE, on DATA write: load TX shift register with WDATA[XFER_BITS-1:0], clear half-period counter and edge counter, go to SHIFT.
- SHIFT: the counter counts 0..DIV. At DIV it wraps, SCK toggles, and the edge counter increments. After 2*XFER_BITS edges, go to FINISH.
- Leading edges are the odd edges (1,3,...); trailing edges are the even edges.
- CPHA=0: first MOSI bit is valid from the load cycle; sample MISO on leading edges; shift out on trailing edges.
- CPHA=1: shift out on leading edges; sample on trailing edges.
- Bit order: MSB first unless LSB_FIRST is set.
- FINISH (1 clock): copy RX shift register to RX register, set DONE, go to IDLE.
- SCK idles at CPOL whenever not in SHIFT. MOSI holds the last driven bit.
- SPI_CS = ~CS_MASK when AUTO_CS=0.
- AUTO_CS=1: SPI_CS = ~CS_MASK during SHIFT and FINISH only, all ones otherwise.
- Busy rules:
  - DATA write while BUSY: ignored, sets OVERRUN.
  - CONTROL or DIVIDER write while BUSY: ignored, no flag.
  - All writes and reads are still ACKed.
- DONE set (FINISH) and DATA read in the same cycle: set wins.
- OVERRUN set and STATUS read in the same cycle: set wins.

## Timing
- Reset values (every output, next edge after RESET high, including mid-transfer):
  - SPI_CS all ones, SPI_SCK 0, SPI_MOSI 0.
  - BUSY 0, IRQ 0, ACK 0, RDATA 0.
  - CONTROL 0, DIVIDER 0, DONE 0, OVERRUN 0, RX 0, state IDLE.
- ACK and RDATA: exactly 1 cycle after the strobe edge, for 1 cycle.
- BUSY rises the cycle after the DATA-write edge and stays high for 2*XFER_BITS*(DIV+1)+1 clocks (SHIFT plus FINISH).
- DONE and IRQ rise on the edge that ends FINISH, coincident with BUSY falling.
- A new DATA write is accepted in the first cycle BUSY reads 0. Transfers run back-to-back with no dead cycle.
- Edge counter width is ceil(log2(2*XFER_BITS+1)). Divider comparison uses the full DIV_WIDTH and does not overflow.

## Test plan
- Mode 0, DIV=0, XFER_BITS=8, AUTO_CS=1, CS_MASK=0x01, write 0xA5 with MISO looped to MOSI:
  - BUSY is high for 17 clocks.
  - SCK shows 8 rising edges and idles low.
  - SPI_CS[0] is low only during the transfer.
  - DATA read returns 0x00A5 and clears DONE.
- Mode 3, LSB_FIRST, DIV=3, write 0x3C, MISO driven 0x81 LSB-first:
  - SCK idles high with a half-period of 4 clocks.
  - MOSI sequence is 0,0,1,1,1,1,0,0.
  - RX reads 0x0081.
  - BUSY length is 65 clocks.
- DATA write during BUSY:
  - TX is unchanged; STATUS reads 0x0005.
  - A second STATUS read returns 0x0001.
  - ACK pulses on every access.
- IRQ_EN=1: IRQ rises with DONE and falls on the cycle after the DATA read. A DATA read in the FINISH cycle leaves DONE=1.
- RESET asserted at edge 5 of a transfer: next cycle SPI_CS=all ones, SCK=0, BUSY=0, CONTROL=0, STATUS=0.
